ctrl_ramdrv_coefgen: RTL
========================

# ctrl_ramdrv_coefgen

Multi-channel coefficient address generator for the polyphase FIR coefficient RAM. It holds a base pointer, tap count and address stride for each of `CH_NUM` filter channels. On a start request it walks one channel's coefficient region from a selectable phase offset. It sits in the controller's RAM driver in place of the single-channel coefficient counter, feeding `coef_addr` to the coefficient RAM and `coef_last`/`done` to the MAC sequencer.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, coefficient RAM address width
- `CH_NUM`, 4, number of channel configuration slots
- `CH_WIDTH`, 2, channel index width; `2**CH_WIDTH >= CH_NUM`
- `LEN_WIDTH`, 8, tap-count field width; the field is encoded as length-1

Ports:
- `clk`  in  1  clock; all state updates on the falling edge
- `clr_n`  in  1  reset, asynchronous, active-low
- `cfg_we`  in  1  configuration write strobe
- `cfg_ch`  in  CH_WIDTH  channel slot written
- `cfg_base`  in  ADDR_WIDTH  channel base pointer
- `cfg_len_m1`  in  LEN_WIDTH  taps per pass minus 1
- `cfg_stride`  in  ADDR_WIDTH  address increment per tap
- `start`  in  1  start a pass; accepted only in IDLE
- `start_ch`  in  CH_WIDTH  channel for the pass
- `start_phase`  in  ADDR_WIDTH  offset added to base for the first tap
- `cnt`  in  1  advance to the next tap
- `abort`  in  1  terminate the pass
- `coef_addr`  out  ADDR_WIDTH  current coefficient address
- `coef_vld`  out  1  `coef_addr` is a valid tap address
- `coef_last`  out  1  current tap is the final tap of the pass
- `done`  out  1  one-cycle pulse after the last tap is consumed
- `busy`  out  1  pass in progress
- `cur_ch`  out  CH_WIDTH  channel of the current or last pass

## Operation
- Config table: `CH_NUM` entries of {base, len_m1, stride}.
  - Reset values: base=0, len_m1=0, stride=1.
  - `cfg_we` with `cfg_ch >= CH_NUM` is ignored.
  - Writes are allowed in any state.
- FSM states: IDLE and RUN.
- IDLE:
  - `start=1` with `start_ch < CH_NUM` does the following: latch the entry's len_m1 and stride into working registers; set `coef_addr <= base + start_phase` (mod 2^ADDR_WIDTH); set `tap_cnt <= 0`; set `cur_ch <= start_ch`; go to RUN.
  - `start` with an invalid channel is ignored.
- RUN:
  - `cnt=1` and `tap_cnt != len_m1`: `coef_addr <= coef_addr + stride` (wraps mod 2^ADDR_WIDTH), `tap_cnt <= tap_cnt + 1`.
  - `cnt=1` and `tap_cnt == len_m1`: go to IDLE and pulse `done`. `coef_addr` holds its last value.
  - `abort=1` has priority over `cnt`: go to IDLE, no `done` pulse, `coef_addr` holds.
  - `start` in RUN is ignored.
- Config written during RUN, including the active channel, affects only later passes, because the working registers are latched at start.
- When `cfg_we` and `start` target the same channel in the same cycle, start uses the pre-write entry values.
- Outputs:
  - `busy = coef_vld = (state == RUN)`
  - `coef_last = busy && (tap_cnt == len_m1)`, combinational from registers
  - `done` is registered.
- `len_m1 = 0` gives a single-tap pass: `coef_last` is high from the first RUN cycle.

## Timing
- Reset (asynchronous, `clr_n=0`):
  - state=IDLE, `coef_addr=0`, `tap_cnt=0`, `cur_ch=0`.
  - `coef_vld`, `coef_last`, `done` and `busy` are all 0.
  - The config table returns to its reset values.
- Reset mid-pass aborts the pass immediately without a `done` pulse.
- Start latency: the first address is valid after the falling edge that samples `start`. `coef_vld` rises on that same edge.
- One tap per `cnt` cycle with no bubbles. A pass of N taps takes N `cnt` cycles.
- `done` is high for exactly one cycle, starting at the edge that consumes the last tap. `busy` falls on that same edge.
- A new `start` may be sampled on the cycle `done` is high, giving back-to-back passes with one idle cycle.
- Address arithmetic is unsigned ADDR_WIDTH; overflow wraps silently, with no flag.

## Test plan
- Reset, write ch1 {base=0x100, len_m1=3, stride=1}, start ch1 phase 0, `cnt` held high -> addresses 0x100, 0x101, 0x102, 0x103; `coef_last` on 0x103; one `done` pulse; `busy` then 0.
- ch2 {base=0x200, len_m1=2, stride=4}, start phase 2 -> addresses 0x202, 0x206, 0x20A; gapped `cnt` (1,0,1,0,1) holds the address during the gaps.
- Wrap: ch0 {base=0xFFE, len_m1=3, stride=1} -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- `abort` on the second tap -> IDLE, no `done`, `coef_addr` held; `start` during RUN ignored; `start_ch=3` with `CH_NUM=3` ignored.
- Same-cycle `cfg_we` and `start` on ch1 -> the pass uses the old base; the next pass uses the new base. `len_m1=0` -> a single tap, with `coef_last` and `done` as specified.
- Assert `clr_n` low mid-pass asynchronously -> all outputs 0 immediately; the config table is back at {0, 0, 1}.

Source files
------------

// File: rtl/ctrl_ramdrv_coefgen.sv
// Multi-channel coefficient address generator for the polyphase FIR coefficient RAM.
// Walks one channel's coefficient region per pass; state updates on the falling clock edge.
module ctrl_ramdrv_coefgen #(
    parameter int ADDR_WIDTH = 12,
    parameter int CH_NUM     = 4,
    parameter int CH_WIDTH   = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  cfg_we,
    input  logic [CH_WIDTH-1:0]   cfg_ch,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_len_m1,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic                  start,
    input  logic [CH_WIDTH-1:0]   start_ch,
    input  logic [ADDR_WIDTH-1:0] start_phase,
    input  logic                  cnt,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] coef_addr,
    output logic                  coef_vld,
    output logic                  coef_last,
    output logic                  done,
    output logic                  busy,
    output logic [CH_WIDTH-1:0]   cur_ch
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] STRIDE_RST = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_r, addr_nxt;
    logic [LEN_WIDTH-1:0]  tap_cnt, tap_nxt;
    logic [LEN_WIDTH-1:0]  len_r, len_nxt;
    logic [ADDR_WIDTH-1:0] stride_r, stride_nxt;
    logic [CH_WIDTH-1:0]   ch_r, ch_nxt;
    logic                  done_r, done_nxt;

    logic [ADDR_WIDTH-1:0] base_tbl   [CH_NUM];
    logic [LEN_WIDTH-1:0]  len_tbl    [CH_NUM];
    logic [ADDR_WIDTH-1:0] stride_tbl [CH_NUM];

    function automatic logic ch_ok(input logic [CH_WIDTH-1:0] ch);
        return (32'(ch) < CH_NUM);
    endfunction

    // Table writes land on the same edge that a start reads it, so a start
    // in the write cycle sees the pre-write entry.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                base_tbl[i]   <= '0;
                len_tbl[i]    <= '0;
                stride_tbl[i] <= STRIDE_RST;
            end
        end else if (cfg_we && ch_ok(cfg_ch)) begin
            base_tbl[cfg_ch]   <= cfg_base;
            len_tbl[cfg_ch]    <= cfg_len_m1;
            stride_tbl[cfg_ch] <= cfg_stride;
        end
    end

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            addr_r   <= '0;
            tap_cnt  <= '0;
            len_r    <= '0;
            stride_r <= '0;
            ch_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_r   <= addr_nxt;
            tap_cnt  <= tap_nxt;
            len_r    <= len_nxt;
            stride_r <= stride_nxt;
            ch_r     <= ch_nxt;
            done_r   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_r;
        tap_nxt    = tap_cnt;
        len_nxt    = len_r;
        stride_nxt = stride_r;
        ch_nxt     = ch_r;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start && ch_ok(start_ch)) begin
                    len_nxt    = len_tbl[start_ch];
                    stride_nxt = stride_tbl[start_ch];
                    addr_nxt   = base_tbl[start_ch] + start_phase;
                    tap_nxt    = '0;
                    ch_nxt     = start_ch;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                // Abort wins over cnt; the address is left on the last tap presented.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt) begin
                    if (tap_cnt == len_r) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        addr_nxt = addr_r + stride_r;
                        tap_nxt  = tap_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign coef_vld  = busy;
    assign coef_last = busy && (tap_cnt == len_r);
    assign coef_addr = addr_r;
    assign cur_ch    = ch_r;
    assign done      = done_r;

endmodule
